// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths and buffer state type for audio_out_buffer
package audio_pkg;

  localparam int SAMPLE_W   = 32;
  localparam int UNDERRUN_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/audio_fifo_mem.sv
// rtl/audio_fifo_mem.sv - synchronous sample FIFO: storage, wrap pointers, level, full/empty
module audio_fifo_mem
  import audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   in_clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [SAMPLE_W-1:0]    i_push_data,
  input  logic                   i_pop,
  output logic [SAMPLE_W-1:0]    o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge in_clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == (AW+1)'(DEPTH));
  assign o_empty = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/audio_out_buffer.sv
// rtl/audio_out_buffer.sv - prefetching sample buffer feeding I2SSender, one pulse per request tick
// Optional AUDIO_OUT_SILENCE_EN: a miss emits a zero sample pulse instead of nothing.
module audio_out_buffer
  import audio_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
) (
  input  logic                      in_clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      wr_valid,
  input  logic [SAMPLE_W-1:0]       wr_data,
  output logic                      wr_ready,
  output logic                      host_req,
  input  logic                      req_tick,
  input  logic                      req_mode,
  output logic                      out_valid,
  output logic [SAMPLE_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic [UNDERRUN_W-1:0]     underrun_cnt,
  output logic                      overflow
);

  localparam int LW = $clog2(DEPTH) + 1;

  buf_state_t            r_state;
  buf_state_t            w_state_nxt;
  logic                  r_outstanding;
  logic                  r_host_req;
  logic                  r_out_valid;
  logic [SAMPLE_W-1:0]   r_out_data;
  logic [UNDERRUN_W-1:0] r_underrun_cnt;
  logic                  r_overflow;

  logic [LW-1:0]         w_level;
  logic [SAMPLE_W-1:0]   w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_miss;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_req_fire;

  audio_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .in_clk      (in_clk),
    .rst_n       (rst_n),
    .i_clear     (flush),
    .i_push      (w_push),
    .i_push_data (wr_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (w_level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_tick && req_mode) w_state_nxt = FILL;
      end
      FILL: begin
        if (req_tick && !req_mode) begin
          w_state_nxt = IDLE;
        end else begin
          w_miss = req_tick;
          if (w_level >= LW'(THRESH)) w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (req_tick) begin
          if (!req_mode) begin
            w_state_nxt = IDLE;
          end else if (w_empty) begin
            w_miss      = 1'b1;
            w_state_nxt = FILL;
          end else begin
            w_pop = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_pop       = 1'b0;
      w_miss      = 1'b0;
    end
  end

  // A pop in the same cycle frees the slot, so a write against a full FIFO still lands.
  assign w_push     = wr_valid && (!w_full || w_pop) && !flush;
  assign w_drop     = wr_valid && w_full && !w_pop;
  assign w_req_fire = (r_state != IDLE) && !r_outstanding &&
                      (w_level < LW'(DEPTH - 1)) && !flush;

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_outstanding  <= 1'b0;
      r_host_req     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_underrun_cnt <= '0;
      r_overflow     <= 1'b0;
    end else if (flush) begin
      r_state        <= IDLE;
      r_outstanding  <= 1'b0;
      r_host_req     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_underrun_cnt <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_host_req  <= w_req_fire;
      r_out_valid <= w_pop;
      if (w_req_fire)            r_outstanding <= 1'b1;
      else if (w_push || w_drop) r_outstanding <= 1'b0;
      if (w_pop) r_out_data <= w_head;
`ifdef AUDIO_OUT_SILENCE_EN
      if (w_miss) begin
        r_out_valid <= 1'b1;
        r_out_data  <= '0;
      end
`endif
      if (w_miss && (r_underrun_cnt != '1)) r_underrun_cnt <= r_underrun_cnt + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign wr_ready     = !w_full;
  assign host_req     = r_host_req;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign level        = w_level;
  assign underrun_cnt = r_underrun_cnt;
  assign overflow     = r_overflow;

endmodule

// File: doc/audio_out_buffer.md
# audio_out_buffer

Sample buffer between the NeXT sound-out packet decoder and `I2SSender`, in the `in_clk` domain. Requests samples from the NeXT hardware ahead of need, buffers them in a small FIFO, and answers each `I2SSender` request tick with exactly one 32-bit stereo sample pulse on `in_valid`/`in_data`. The buffer absorbs NeXT bus latency, so the serial side never waits on a round trip.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 4..64.
- `THRESH`, 4: level at which FILL hands over to RUN; 1..DEPTH.
- `in_clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of the FIFO and state.
- `wr_valid` in 1: sample word from the NeXT sound-out decoder.
- `wr_data` in 32: sample, {L[31:16], R[15:0]}.
- `wr_ready` out 1: FIFO not full.
- `host_req` out 1: one-cycle pulse asking the NeXT hardware for the next sample.
- `req_tick` in 1: from `I2SSender.audio_req_tick`, one-cycle pulse.
- `req_mode` in 1: from `I2SSender.audio_req_mode_out`; samples wanted.
- `out_valid` out 1: to `I2SSender.in_valid`, one-cycle pulse.
- `out_data` out 32: to `I2SSender.in_data`, valid with `out_valid`.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `underrun_cnt` out 16: ticks served with no data; saturates at 16'hFFFF.
- `overflow` out 1: sticky; a write arrived while full.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `host_req`=0, `level`=0, `underrun_cnt`=0, `overflow`=0, `wr_ready`=1, state IDLE, outstanding=0.
- **IDLE**
  - No pops. Writes are still accepted.
  - A `req_tick` with `req_mode`=1 moves to FILL.
- **FILL**
  - Ticks do not pop; each tick is a miss.
  - Move to RUN when `level`>=THRESH.
  - A `req_tick` with `req_mode`=0 moves to IDLE.
- **RUN**
  - A tick with `level`>0 pops the head into `out_data` and pulses `out_valid`.
  - A tick with `level`=0 is a miss; move to FILL.
  - A tick with `req_mode`=0 moves to IDLE with no pop.
- **Miss:** `underrun_cnt`+1 (saturating). Output behaviour depends on the macro in Configuration.
- **Fetch handshake**
  - `host_req` pulses when state is FILL or RUN, outstanding=0, and `level`+1 < DEPTH.
  - The pulse sets outstanding. The next accepted write clears it.
  - At most one request is in flight.
- **Writes**
  - Accepted when `wr_valid`&`wr_ready`.
  - `wr_valid` while full: word dropped, `overflow` set, outstanding cleared.
- **Simultaneous events**
  - Push and pop in the same cycle: `level` unchanged. Allowed when full, since `wr_ready` reflects the pre-pop level; the pop frees the slot.
  - Pop on empty never happens (it is a miss).
- **`flush`:** pointers and `level` to 0, outstanding to 0, state IDLE, `out_valid` to 0. `underrun_cnt` and `overflow` are also cleared. `flush` has priority over everything in the same cycle.
- Pointers wrap modulo DEPTH. `level` = wr_ptr − rd_ptr using one extra pointer bit.

## Timing
- `out_valid`/`out_data` are registered and appear 1 cycle after `req_tick`.
- `out_data` holds its value until the next pop.
- `host_req` is registered. It fires no earlier than 1 cycle after the enabling condition and is never high in two consecutive cycles.
- State transitions and `level` update on the edge that samples the causing input.
- `rst_n` asserted mid-stream clears everything immediately, asynchronously. Any `host_req` in flight is forgotten.

## Configuration
- Macro: `AUDIO_OUT_SILENCE_EN`.
- Defined: every miss pulses `out_valid` with `out_data`=32'h0, so `I2SSender` plays silence.
- Undefined: a miss produces no `out_valid` and `out_data` is unchanged. `I2SSender` repeats or idles per its own rules.
- `underrun_cnt` counts misses in both builds.

## Structure
- Package `audio_pkg` holds:
  - `SAMPLE_W`=32.
  - The state enum `buf_state_t` {IDLE, FILL, RUN}.
  - `UNDERRUN_W`=16.
- Sub-module `audio_fifo_mem` holds the sync FIFO: storage, pointers, level, full/empty.
- The top level holds the FSM, fetch handshake and counters.

## Test plan
- Reset, then `req_mode`=1 and a tick → FILL. `host_req` pulses. Reply to each request with 1,2,3,4 → RUN at `level`=4, `host_req` continues until `level`=7.
- RUN with `level`=3 and a tick → 1 cycle later `out_valid`=1, `out_data`=head word; `level`=2.
- Drain to empty, then a tick → `underrun_cnt`=1, state FILL. `out_valid`=1 with 0 only when `AUDIO_OUT_SILENCE_EN` is defined.
- Fill to 8, unsolicited `wr_valid` with 32'hDEAD_BEEF → dropped, `overflow`=1, `level`=8. Tick plus write in the same cycle → `level` stays 8.
- `req_mode`=0 at a tick in RUN → IDLE, no pop. `flush` → `level`=0, counters cleared.
- `rst_n` low for 1 ns mid-fetch → all outputs at reset values immediately. No stale `host_req` after release.
